wptr_full: RTL and testbench
============================

# wptr_full

Write-side pointer and full-flag controller for the asynchronous FIFO; the write-clock-domain counterpart of the read-pointer/empty logic. It keeps the binary write address and the Gray write pointer, and compares them against the read pointer after it has been synchronized into the write domain. From that it produces registered full, almost-full and free-space outputs, plus a sticky overflow flag. It sits between the FIFO write port, the dual-port memory write address, and the write-to-read pointer synchronizer.

## Interface
- `ASIZE`, default 4: address width. FIFO depth is 2^ASIZE. Legal range is ASIZE >= 2.
- `wclk` input, 1 bit: write clock. All state changes on the rising edge.
- `wrst_n` input, 1 bit: reset. Synchronous, active-low.
- `winc` input, 1 bit: write request. Accepted only when `wfull`=0.
- `wq2_rptr` input, ASIZE+1 bits: Gray read pointer, already double-synchronized into `wclk`.
- `wovf_clr` input, 1 bit: clears the sticky overflow flag.
- `wfull` output, 1 bit: registered. FIFO is full.
- `awfull` output, 1 bit: registered. Exactly one free slot remains.
- `waddr` output, ASIZE bits: memory write address, equal to `wbin[ASIZE-1:0]`.
- `wptr` output, ASIZE+1 bits: registered Gray write pointer, sent to the read-domain synchronizer.
- `wfree` output, ASIZE+1 bits: registered free-slot count, range 0..2^ASIZE.
- `wovf` output, 1 bit: sticky. A write was attempted while full.

## Operation
Internal state:
- `wbin`, ASIZE+1-bit binary write counter.
- The registered outputs listed above.

Combinational terms:
- `wpush = winc & ~wfull`
- `wbinnext = wbin + wpush`, modulo 2^(ASIZE+1)
- `wgraynext = (wbinnext >> 1) ^ wbinnext`
- `rbin_s` = Gray-to-binary conversion of `wq2_rptr`: bit i is the XOR of `wq2_rptr[ASIZE:i]`.
- `used_next = (wbinnext - rbin_s)` modulo 2^(ASIZE+1)
- `free_next = 2^ASIZE - used_next`
- `wfull_val = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]})`. This must agree with `free_next == 0`; assert the equivalence in simulation.
- `awfull_val = (free_next == 1)`

Register updates each edge when `wrst_n`=1:
- `wbin <= wbinnext`, `wptr <= wgraynext`
- `wfull <= wfull_val`, `awfull <= awfull_val`, `wfree <= free_next`
- `wovf`: set if `winc & wfull`; otherwise cleared if `wovf_clr`; otherwise hold. Set has priority when set and clear occur together.

Reset, any edge with `wrst_n`=0:
- `wbin`=0, `wptr`=0, `waddr`=0.
- `wfull`=0, `awfull`=0, `wfree`=2^ASIZE, `wovf`=0.

Boundary behaviour:
- **Write while full:** ignored. Pointer, address and `wfree` are unchanged, `wovf` sets, and the memory write enable (`winc & ~wfull`, generated outside this block) stays low.
- **Wrap-around:** `wbin` rolls from 2^(ASIZE+1)-1 to 0. The MSB toggles every 2^ASIZE writes, and the full and free computations stay correct across the wrap.
- **Simultaneous write and pointer advance:** `free_next` uses both the new `wbinnext` and the new `wq2_rptr`, so the count is exact in the same cycle.
- **Reset mid-operation:** all state returns to reset values on that edge regardless of `winc`. The read side must be reset in the same window; that is a system-level requirement.
- **Stale `wq2_rptr`:** this only makes full/free pessimistic and never overflows the FIFO. Correctness relies on `wq2_rptr` changing by at most one bit per `wclk`.

## Timing
- **Write accepted at edge N:** `waddr` and `wptr` advance at edge N, and the memory is written at edge N using the old `waddr`.
- **Full after a write:** `wfull`, `awfull` and `wfree` reflect the post-write state at the same edge N; there is no extra latency. The write that fills the FIFO raises `wfull` at the same edge it is accepted.
- **Release after a read:** a change on `wq2_rptr` is reflected in `wfull`, `awfull` and `wfree` one `wclk` edge later.
- **Overflow flag:** `wovf` rises at the edge after the rejected `winc` is sampled.
- **End-to-end:** total read-to-write-side release latency is 2 (synchronizer) + 1 `wclk` cycles.

## Test plan
1. **Reset:** assert `wrst_n`=0 for 2 cycles with `winc`=1 → `wptr`=0, `waddr`=0, `wfree`=16, `wfull`=0, `awfull`=0, `wovf`=0.
2. **Fill:** ASIZE=4, `wq2_rptr`=0, 16 back-to-back writes → after the 15th, `awfull`=1 and `wfree`=1. After the 16th, `wfull`=1, `awfull`=0, `wfree`=0, `wptr`=5'b11000, `waddr`=0.
3. **Overflow:** while full, hold `winc`=1 for 3 cycles → `wptr` stays 5'b11000 and `wovf`=1. Then pulse `wovf_clr` with `winc`=0 → `wovf`=0. Pulse `wovf_clr` with `winc`=1 → `wovf` stays 1.
4. **Release:** from full, set `wq2_rptr`=5'b00001 (binary 1) → next edge `wfull`=0, `awfull`=1, `wfree`=1. Write once → `wfull`=1.
5. **Wrap-around:** 40 writes with `wq2_rptr` tracking at a lag of 3 entries → `wfree` is 13 after each write, `wfull` is never set, `wbin` passes 31→0, and `wptr` equals gray(40 mod 32)=gray(8)=5'b01100.
6. **Reset mid-fill:** after 7 writes, drop `wrst_n` for 1 cycle while `winc`=1 → all outputs return to reset values on that edge, and the next accepted write yields `waddr`=1.

Source files
------------

// File: rtl/wptr_full.sv
// Write pointer, full/almost-full flags, free count and sticky overflow
// for the write-clock side of an asynchronous FIFO.
//
// Ports:
//   wclk      write clock; all state changes on its rising edge
//   wrst_n    synchronous active-low reset
//   winc      write request, accepted only while wfull is low
//   wq2_rptr  Gray read pointer, already synchronized into wclk
//   wovf_clr  clears the sticky overflow flag (a new overflow wins)
//   wfull     registered: FIFO full
//   awfull    registered: exactly one free slot left
//   waddr     memory write address (low bits of the binary counter)
//   wptr      registered Gray write pointer for the read side
//   wfree     registered free-slot count, 0..2^ASIZE
//   wovf      sticky: a write was attempted while full
module wptr_full #(
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             wovf_clr,
  output logic             wfull,
  output logic             awfull,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic [ASIZE:0]   wfree,
  output logic             wovf
);

  localparam logic [ASIZE:0] DEPTH =
    (ASIZE+1)'(1) << ASIZE;
  localparam logic [ASIZE:0] ONE =
    (ASIZE+1)'(1);

  logic [ASIZE:0] wbin_q, wbin_d;
  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] wfree_q, wfree_d;
  logic           wfull_q, wfull_d;
  logic           awfull_q, awfull_d;
  logic           wovf_q, wovf_d;

  logic           wpush;
  logic [ASIZE:0] wbinnext;
  logic [ASIZE:0] wgraynext;
  logic [ASIZE:0] rbin_s;
  logic [ASIZE:0] used_next;
  logic [ASIZE:0] free_next;
  logic [ASIZE:0] rptr_full;
  logic           wfull_val;
  logic           awfull_val;

  always_comb begin
    wpush     = winc & ~wfull_q;
    wbinnext  = wbin_q + {{ASIZE{1'b0}}, wpush};
    wgraynext = (wbinnext >> 1) ^ wbinnext;

    // Gray to binary: bit i is the XOR of bits ASIZE..i.
    rbin_s = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end

    used_next = wbinnext - rbin_s;
    free_next = DEPTH - used_next;

    // Full when pointers differ only in the two MSBs
    // (one lap ahead in Gray space).
    rptr_full = {~wq2_rptr[ASIZE:ASIZE-1],
                 wq2_rptr[ASIZE-2:0]};
    wfull_val  = (wgraynext == rptr_full);
    awfull_val = (free_next == ONE);
  end

  always_comb begin
    wbin_d   = wbinnext;
    wptr_d   = wgraynext;
    wfull_d  = wfull_val;
    awfull_d = awfull_val;
    wfree_d  = free_next;
    wovf_d   = wovf_q;
    if (winc & wfull_q) begin
      wovf_d = 1'b1;
    end else if (wovf_clr) begin
      wovf_d = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      wfree_q  <= DEPTH;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      wfree_q  <= wfree_d;
      wovf_q   <= wovf_d;
    end
  end

  // The Gray full compare and the binary free count must agree.
  always_ff @(posedge wclk) begin
    if (wrst_n) begin
      assert (wfull_val == (free_next == '0));
    end
  end

  assign wfull  = wfull_q;
  assign awfull = awfull_q;
  assign waddr  = wbin_q[ASIZE-1:0];
  assign wptr   = wptr_q;
  assign wfree  = wfree_q;
  assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ASIZE=4).
// Directed table, hand sequences and a count-based random model.
module tb_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic       wovf_clr = 1'b0;
  logic       wfull, awfull, wovf;
  logic [3:0] waddr;
  logic [4:0] wptr, wfree;

  wptr_full #(.ASIZE(4)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .wovf_clr (wovf_clr),
    .wfull    (wfull),
    .awfull   (awfull),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfree    (wfree),
    .wovf     (wovf)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       rst_n;
    logic       winc;
    logic       clr;
    logic [4:0] rptr;
    logic       full;
    logic       aw;
    logic       ovf;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic [4:0] free;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  int   wc, rc;
  logic mfull, movf;

  function automatic logic [4:0] gray(int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mkv(
    logic r, logic w, logic c, logic [4:0] rp,
    logic f, logic a, logic o, int ad, int pt, int fr);
    vec_t v;
    v.rst_n = r; v.winc = w; v.clr = c; v.rptr = rp;
    v.full = f; v.aw = a; v.ovf = o;
    v.addr = 4'(ad); v.ptr = 5'(pt); v.free = 5'(fr);
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  task automatic compare();
    vec_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("wfull", wfull, e.full);
    chk("awfull", awfull, e.aw);
    chk("wovf", wovf, e.ovf);
    chk("waddr", waddr, e.addr);
    chk("wptr", wptr, e.ptr);
    chk("wfree", wfree, e.free);
  endtask

  task automatic step(input vec_t v);
    wrst_n   = v.rst_n;
    winc     = v.winc;
    wovf_clr = v.clr;
    wq2_rptr = v.rptr;
    sb.push_back(v);
    @(posedge wclk);
    #1;
    compare();
  endtask

  // Count-based reference: entries written minus entries read.
  task automatic mstep(input logic r, input logic w,
                       input logic c, input int rcnt,
                       output vec_t v);
    int fr;
    if (!r) begin
      wc = 0; mfull = 0; movf = 0;
      v = mkv(0, w, c, gray(rcnt), 0, 0, 0, 0, 0, 16);
      return;
    end
    if (w && mfull) movf = 1;
    else if (c) movf = 0;
    if (w && !mfull) wc++;
    fr = 16 - (wc - rcnt);
    mfull = (fr == 0);
    v = mkv(1, w, c, gray(rcnt), mfull, fr == 1,
            movf, wc % 16, gray(wc % 32), fr);
  endtask

  initial begin
    vec_t v;
    // Reset held with winc=1
    tbl.push_back(mkv(0,1,0,0, 0,0,0, 0,0,16));
    tbl.push_back(mkv(0,1,0,0, 0,0,0, 0,0,16));
    // Fill 16 with rptr at 0
    for (int i = 1; i <= 16; i++)
      tbl.push_back(mkv(1,1,0,0, i == 16, i == 15, 0,
                        i % 16, gray(i), 16 - i));
    // Overflow while full
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv(1,1,0,0, 1,0,1, 0,5'b11000,0));
    // Clear with a simultaneous rejected write: stays set
    tbl.push_back(mkv(1,1,1,0, 1,0,1, 0,5'b11000,0));
    tbl.push_back(mkv(1,0,1,0, 1,0,0, 0,5'b11000,0));
    tbl.push_back(mkv(1,1,0,0, 1,0,1, 0,5'b11000,0));
    tbl.push_back(mkv(1,0,0,0, 1,0,1, 0,5'b11000,0));
    tbl.push_back(mkv(1,0,1,0, 1,0,0, 0,5'b11000,0));
    // Release one slot, then refill it
    tbl.push_back(mkv(1,0,0,1, 0,1,0, 0,5'b11000,1));
    tbl.push_back(mkv(1,1,0,1, 1,0,0, 1,5'b11001,0));
    tbl.push_back(mkv(1,0,0,1, 1,0,0, 1,5'b11001,0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Wrap-around: 40 writes, read side lagging by 3
    rc = 0;
    mstep(0, 0, 0, 0, v); step(v);
    for (int k = 1; k <= 40; k++) begin
      rc = (k > 3) ? k - 3 : 0;
      mstep(1, 1, 0, rc, v); step(v);
      if (k >= 3) chk("wrap_free13", wfree, 13);
      chk("wrap_nofull", wfull, 0);
    end
    chk("wrap_wptr", wptr, 5'b01100);
    chk("wrap_waddr", waddr, 8);

    // Reset mid-fill with winc held
    mstep(0, 0, 0, 0, v); step(v);
    for (int k = 0; k < 7; k++) begin
      mstep(1, 1, 0, 0, v); step(v);
    end
    chk("mid_waddr7", waddr, 7);
    mstep(0, 1, 0, 0, v); step(v);
    mstep(1, 1, 0, 0, v); step(v);
    chk("post_rst_waddr", waddr, 1);
    chk("post_rst_free", wfree, 15);

    // Random traffic against the count model
    rc = 0;
    mstep(0, 0, 0, 0, v); step(v);
    for (int k = 0; k < 400; k++) begin
      logic r, w, c;
      r = ($urandom_range(0, 99) != 0);
      w = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 7) == 0);
      if (!r) rc = 0;
      else if (rc < wc && $urandom_range(0, 2) == 0)
        rc++;
      mstep(r, w, c, rc, v); step(v);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

endmodule
